// File: rtl/dot_seq_pkg.sv
// Shared types and default dimensions for the dot-matrix scan path.
// MEM_LENGTH_DEF must agree with the dot_sequencer build.
package dot_seq_pkg;

   localparam int MEM_LENGTH_DEF         = 48;
   localparam int MEM_ADDRESS_LENGTH_DEF = 6;
   localparam int DWELL_WIDTH_DEF        = 16;
   localparam int DEAD_WIDTH_DEF         = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_DWELL  = 2'd2,
      S_DEAD   = 2'd3
   } scan_state_e;

endpackage

// File: rtl/dot_scan_counter.sv
// 2-D scan address counter: steps (row, col) through a rectangle in
// row-major or column-major order and wraps to (0,0) after the last dot.
module dot_scan_counter #(
   parameter int ADDR_W = 6
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic [ADDR_W-1:0] row_limit_i,
   input  logic [ADDR_W-1:0] col_limit_i,
   input  logic              col_major_i,
   input  logic              advance_i,
   input  logic              clear_i,
   output logic [ADDR_W-1:0] row_o,
   output logic [ADDR_W-1:0] col_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0] col_q, col_d;

   assign last_o = (row_q == row_limit_i) && (col_q == col_limit_i);
   assign row_o  = row_q;
   assign col_o  = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
      end else if (advance_i) begin
         if (last_o) begin
            row_d = '0;
            col_d = '0;
         end else if (!col_major_i) begin
            if (col_q < col_limit_i) begin
               col_d = col_q + ADDR_W'(1);
            end else begin
               col_d = '0;
               row_d = row_q + ADDR_W'(1);
            end
         end else begin
            if (row_q < row_limit_i) begin
               row_d = row_q + ADDR_W'(1);
            end else begin
               row_d = '0;
               col_d = col_q + ADDR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/dot_scan_controller.sv
// Dot-matrix scan controller: per dot, one settle cycle, a dwell window with
// drive = firing_bit & firing_data, then an optional dead gap.
module dot_scan_controller
   import dot_seq_pkg::*;
#(
   parameter int MEM_LENGTH         = MEM_LENGTH_DEF,
   parameter int MEM_ADDRESS_LENGTH = MEM_ADDRESS_LENGTH_DEF,
   parameter int DWELL_WIDTH        = DWELL_WIDTH_DEF,
   parameter int DEAD_WIDTH         = DEAD_WIDTH_DEF
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          continuous,
   input  logic                          col_major,
   input  logic [MEM_ADDRESS_LENGTH-1:0] row_limit,
   input  logic [MEM_ADDRESS_LENGTH-1:0] col_limit,
   input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
   input  logic [DEAD_WIDTH-1:0]         dead_cycles,
   input  logic                          firing_bit,
   input  logic                          firing_data,
   output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
   output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
   output logic                          row_col_select,
   output logic                          drive,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int AW1 = MEM_ADDRESS_LENGTH + 1;
   localparam logic [AW1-1:0] MEM_LEN_W = AW1'(MEM_LENGTH);
   localparam logic [MEM_ADDRESS_LENGTH-1:0] LIMIT_MAX = MEM_ADDRESS_LENGTH'(MEM_LENGTH - 1);

   function automatic logic [MEM_ADDRESS_LENGTH-1:0] clamp_limit(
      input logic [MEM_ADDRESS_LENGTH-1:0] v);
      if ({1'b0, v} >= MEM_LEN_W) return LIMIT_MAX;
      else return v;
   endfunction

   scan_state_e                   state_q;
   logic                          continuous_q, col_major_q;
   logic [MEM_ADDRESS_LENGTH-1:0] row_limit_q, col_limit_q;
   logic [DWELL_WIDTH-1:0]        dwell_q, dwell_cnt_q;
   logic [DEAD_WIDTH-1:0]         dead_q, dead_cnt_q;
   logic                          drive_q, frame_done_q;
   logic                          dot_end, advance, clear, last;

   // A dot ends on the last dwell cycle when there is no dead gap, else on the last dead cycle.
   assign dot_end = ((state_q == S_DWELL) && (dwell_cnt_q == '0) && (dead_q == '0)) ||
                    ((state_q == S_DEAD) && (dead_cnt_q == '0));
   assign advance = dot_end && !stop;
   assign clear   = ((state_q == S_IDLE) && start && !stop) || ((state_q != S_IDLE) && stop);

   dot_scan_counter #(.ADDR_W(MEM_ADDRESS_LENGTH)) u_counter (
      .clock_i     (clock),
      .reset_n_i   (reset_n),
      .row_limit_i (row_limit_q),
      .col_limit_i (col_limit_q),
      .col_major_i (col_major_q),
      .advance_i   (advance),
      .clear_i     (clear),
      .row_o       (row_select),
      .col_o       (col_select),
      .last_o      (last)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         continuous_q <= 1'b0;
         col_major_q  <= 1'b0;
         row_limit_q  <= '0;
         col_limit_q  <= '0;
         dwell_q      <= '0;
         dead_q       <= '0;
         dwell_cnt_q  <= '0;
         dead_cnt_q   <= '0;
         drive_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !stop) begin
                  continuous_q <= continuous;
                  col_major_q  <= col_major;
                  row_limit_q  <= clamp_limit(row_limit);
                  col_limit_q  <= clamp_limit(col_limit);
                  dwell_q      <= (dwell_cycles == '0) ? DWELL_WIDTH'(1) : dwell_cycles;
                  dead_q       <= dead_cycles;
                  state_q      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               drive_q     <= firing_bit & firing_data;
               dwell_cnt_q <= dwell_q - DWELL_WIDTH'(1);
               state_q     <= S_DWELL;
            end
            S_DWELL: begin
               if (dwell_cnt_q == '0) begin
                  drive_q <= 1'b0;
                  if (dead_q != '0) begin
                     dead_cnt_q <= dead_q - DEAD_WIDTH'(1);
                     state_q    <= S_DEAD;
                  end else if (last) begin
                     frame_done_q <= 1'b1;
                     state_q      <= continuous_q ? S_SETTLE : S_IDLE;
                  end else begin
                     state_q <= S_SETTLE;
                  end
               end else begin
                  dwell_cnt_q <= dwell_cnt_q - DWELL_WIDTH'(1);
               end
            end
            S_DEAD: begin
               if (dead_cnt_q == '0) begin
                  if (last) begin
                     frame_done_q <= 1'b1;
                     state_q      <= continuous_q ? S_SETTLE : S_IDLE;
                  end else begin
                     state_q <= S_SETTLE;
                  end
               end else begin
                  dead_cnt_q <= dead_cnt_q - DEAD_WIDTH'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Abort overrides whatever the dot sequencing decided this cycle.
         if (stop && (state_q != S_IDLE)) begin
            state_q      <= S_IDLE;
            drive_q      <= 1'b0;
            frame_done_q <= 1'b0;
         end
      end
   end

   assign drive          = drive_q;
   assign frame_done     = frame_done_q;
   assign row_col_select = col_major_q;
   assign busy           = (state_q != S_IDLE);

endmodule
